// File: rtl/seq_detect_param.sv
// seq_detect_param: loadable-pattern serial bit detector with registered match pulse
// and saturating match counter, overlapping or non-overlapping detection.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b1101
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pat_load,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] r_pat, r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;

    logic             w_acc, w_hit;
    logic [PAT_W-1:0] w_hist_n;
    logic [FW-1:0]    w_fill_n;

    assign w_acc    = din_valid & ~pat_load;
    assign w_hist_n = {r_hist[PAT_W-2:0], din};
    assign w_fill_n = (r_fill == FULL) ? FULL : r_fill + FW'(1);
    assign w_hit    = w_acc && (w_fill_n == FULL) && (w_hist_n == r_pat);

    // A load restarts the fill window but keeps history; the loading cycle's bit is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat   <= RST_PAT;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_match <= w_hit;
            if (pat_load) begin
                r_pat  <= pattern;
                r_fill <= '0;
            end else if (din_valid) begin
                r_hist <= w_hist_n;
                r_fill <= (w_hit && !overlap_en) ? '0 : w_fill_n;
            end
            if (cnt_clr)
                r_cnt <= '0;
            else if (w_hit && r_cnt != '1)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: randomized and directed checks of seq_detect_param against a
// queue-based model; a second instance with CNT_W=2 exercises counter saturation.
module tb_seq_detect_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0, din_valid = 1'b0, pat_load = 1'b0, overlap_en = 1'b1, cnt_clr = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic       match_a, match_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int vectors = 0;
    int errors = 0;

    seq_detect_param u_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pattern(pattern),
        .pat_load(pat_load), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .match(match_a), .match_cnt(cnt_a)
    );
    seq_detect_param #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1101)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pattern(pattern),
        .pat_load(pat_load), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .match(match_b), .match_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    // Model: every accepted bit in arrival order, plus bits accepted since the window restarted.
    bit         acc[$];
    int         fresh;
    logic [3:0] m_pat;
    logic       m_match;
    int         m_cnt_a, m_cnt_b;

    function automatic logic [3:0] last4();
        logic [3:0] w = '0;
        for (int i = 0; i < 4; i++) w = {w[2:0], logic'(acc[acc.size() - 4 + i])};
        return w;
    endfunction

    task automatic model_reset();
        acc.delete();
        fresh = 0;
        m_pat = 4'b1101;
        m_match = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic step(input logic d, input logic v, input logic l, input logic [3:0] p,
                        input logic o, input logic c);
        bit hit;
        din = d; din_valid = v; pat_load = l; pattern = p; overlap_en = o; cnt_clr = c;
        @(posedge clk);
        hit = 0;
        if (l) begin
            m_pat = p;
            fresh = 0;
        end else if (v) begin
            acc.push_back(d === 1'b1);
            fresh++;
            hit = fresh >= 4 && last4() == m_pat;
            if (hit && !o) fresh = 0;
        end
        m_match = hit;
        if (c) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (hit) begin
            m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
            m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (match_a !== 1'b0 || cnt_a !== 8'd0 || match_b !== 1'b0 || cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL reset: match %b/%b cnt %0d/%0d, required 0/0 0/0", match_a, match_b, cnt_a, cnt_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_stream(input string name, input logic o, input logic [3:0] p,
                              input logic [15:0] bits, input int n, input bit gaps,
                              output int pulses);
        pulses = 0;
        step(1'b0, 1'b0, 1'b1, p, o, 1'b1);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps)
                while ($urandom_range(0, 2) == 0) begin
                    step(1'($urandom), 1'b0, 1'b0, p, o, 1'b0);
                    vectors++;
                    if (match_a !== 1'b0 || match_b !== 1'b0) begin
                        errors++;
                        $display("FAIL %s gap: match %b/%b, required 0", name, match_a, match_b);
                    end
                end
            step(bits[i], 1'b1, 1'b0, p, o, 1'b0);
            pulses += int'(match_a);
            vectors++;
            if (match_a !== m_match || match_b !== m_match || cnt_a !== 8'(m_cnt_a) || cnt_b !== 2'(m_cnt_b)) begin
                errors++;
                $display("FAIL %s bit %0d: match %b/%b cnt %0d/%0d, required %b cnt %0d/%0d",
                         name, n - i, match_a, match_b, cnt_a, cnt_b, m_match, m_cnt_a, m_cnt_b);
            end
        end
    endtask

    task automatic test_overlap();
        int pulses;
        run_stream("overlap", 1'b1, 4'b1101, 16'b1101101, 7, 0, pulses);
        vectors++;
        if (pulses !== 2 || cnt_a !== 8'd2) begin
            errors++;
            $display("FAIL overlap_total: pulses %0d cnt %0d, required 2 2", pulses, cnt_a);
        end
    endtask

    task automatic test_nonoverlap();
        int pulses;
        run_stream("nonoverlap", 1'b0, 4'b1101, 16'b1101101, 7, 0, pulses);
        vectors++;
        if (pulses !== 1 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL nonoverlap_total: pulses %0d cnt %0d, required 1 1", pulses, cnt_a);
        end
    endtask

    task automatic test_gaps();
        int pulses;
        for (int r = 0; r < 4; r++) begin
            run_stream("gaps", 1'b1, 4'b1101, 16'b1101101, 7, 1, pulses);
            vectors++;
            if (pulses !== 2 || cnt_a !== 8'd2) begin
                errors++;
                $display("FAIL gaps_total: pulses %0d cnt %0d, required 2 2", pulses, cnt_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        run_stream("ones_ovl", 1'b1, 4'b1111, 16'h3f, 6, 0, pulses);
        vectors++;
        if (pulses !== 3 || cnt_a !== 8'd3) begin
            errors++;
            $display("FAIL ones_ovl_total: pulses %0d cnt %0d, required 3 3", pulses, cnt_a);
        end
        run_stream("ones_novl", 1'b0, 4'b1111, 16'h3f, 6, 0, pulses);
        vectors++;
        if (pulses !== 1 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL ones_novl_total: pulses %0d cnt %0d, required 1 1", pulses, cnt_a);
        end
    endtask

    task automatic test_saturate();
        int pulses;
        run_stream("saturate", 1'b1, 4'b1111, 16'hff, 8, 0, pulses);
        vectors++;
        if (pulses !== 5 || cnt_b !== 2'd3 || cnt_a !== 8'd5) begin
            errors++;
            $display("FAIL saturate: pulses %0d cnt_b %0d cnt_a %0d, required 5 3 5", pulses, cnt_b, cnt_a);
        end
        step(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1);
        vectors++;
        if (match_a !== 1'b1 || match_b !== 1'b1 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL clr_on_hit: match %b/%b cnt %0d/%0d, required 1 0", match_a, match_b, cnt_a, cnt_b);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [2:0] pre = 3'b110;
        step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1);
        for (int i = 2; i >= 0; i--) step(pre[i], 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (match_a !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: match %b cnt %0d/%0d, required 0 0", match_a, cnt_a, cnt_b);
        end
        din_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] s = 4'b1101;
            step(s[i], 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
            pulses += int'(match_a);
            vectors++;
            if (match_a !== m_match || cnt_a !== 8'(m_cnt_a)) begin
                errors++;
                $display("FAIL post_reset bit %0d: match %b cnt %0d, required %b %0d", 4 - i, match_a, cnt_a, m_match, m_cnt_a);
            end
        end
        vectors++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL post_reset_total: pulses %0d, required 1", pulses);
        end
        for (int i = 2; i >= 0; i--) step(pre[i], 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0);
        vectors++;
        if (match_a !== 1'b0 || match_b !== 1'b0 || m_match !== 1'b0) begin
            errors++;
            $display("FAIL load_ignores_bit: match %b/%b, required 0", match_a, match_b);
        end
        step(1'b1, 1'b1, 1'b0, 4'b1101, 1'b1, 1'b0);
        vectors++;
        if (match_a !== m_match || cnt_a !== 8'(m_cnt_a)) begin
            errors++;
            $display("FAIL after_load: match %b cnt %0d, required %b %0d", match_a, cnt_a, m_match, m_cnt_a);
        end
    endtask

    task automatic test_random();
        logic [3:0] pats [4] = '{4'b1101, 4'b1111, 4'b0101, 4'b0000};
        logic [3:0] p = 4'b1101;
        logic       o = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic l = ($urandom_range(0, 29) == 0);
            if (l) p = pats[$urandom_range(0, 3)];
            if ($urandom_range(0, 19) == 0) o = ~o;
            step(1'($urandom), ($urandom_range(0, 9) < 7), l, p, o, ($urandom_range(0, 39) == 0));
            vectors++;
            if (match_a !== m_match || match_b !== m_match || cnt_a !== 8'(m_cnt_a) || cnt_b !== 2'(m_cnt_b)) begin
                errors++;
                $display("FAIL random cycle %0d: match %b/%b cnt %0d/%0d, required %b cnt %0d/%0d",
                         i, match_a, match_b, cnt_a, cnt_b, m_match, m_cnt_a, m_cnt_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
